// File: rtl/uart_autobaud_if.sv
// Control and receiver-side signals of the autobaud calibrator.
// The master is the host/receiver side; the slave is the calibrator.
interface uart_autobaud_if;
    logic        start;
    logic        frame_error;
    logic        frame_ok;
    logic [15:0] prescale;
    logic        rx_hold;
    logic        locked;
    logic        busy;
    logic        cal_error;

    modport master (
        output start, frame_error, frame_ok,
        input  prescale, rx_hold, locked, busy, cal_error
    );

    modport slave (
        input  start, frame_error, frame_ok,
        output prescale, rx_hold, locked, busy, cal_error
    );
endinterface

// File: rtl/uart_autobaud.sv
// UART autobaud calibrator: times the falling edges of a 0x55 sync
// character on rxd and derives the uart_rx prescale (clk / (baud * 8)).
// Holds the receiver in reset until locked; recalibrates on request or
// after a run of consecutive frame errors.
module uart_autobaud #(
    parameter logic [15:0] DEFAULT_PRESCALE = 16'd54,
    parameter int          IDLE_CYCLES      = 256,
    parameter int          MIN_PRESCALE     = 2,
    parameter int          IVAL_MAX         = 1048575,
    parameter int          ERR_LIMIT        = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rxd,
    uart_autobaud_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_HUNT,
        ST_MEASURE,
        ST_CALC,
        ST_LOCKED
    } state_t;

    localparam logic [8:0]  IDLE_LIM = 9'(IDLE_CYCLES);
    localparam logic [20:0] IVAL_LIM = 21'(IVAL_MAX);
    localparam logic [3:0]  ERR_LIM  = 4'(ERR_LIMIT);
    localparam logic [23:0] P_MIN    = 24'(MIN_PRESCALE);
    localparam logic [23:0] P_MAX    = 24'd65535;

    state_t      state_reg, state_next;
    logic        rxd_m_reg, rxd_s_reg, rxd_d_reg;
    logic [8:0]  run_reg, run_next;
    logic [22:0] cnt_reg, cnt_next;
    logic [20:0] ival_reg, ival_next;
    logic [20:0] ival0_reg, ival0_next;
    logic [2:0]  edge_reg, edge_next;
    logic [3:0]  err_reg, err_next;
    logic [15:0] prescale_reg, prescale_next;
    logic        locked_reg, locked_next;
    logic        cal_error_reg, cal_error_next;

    logic        fe;
    logic [20:0] ival_diff;
    logic [23:0] cnt_round;
    logic [23:0] p_full;
    logic [3:0]  err_inc;

    // Every edge sees the same synchronizer delay, so intervals are exact.
    assign fe        = rxd_d_reg & ~rxd_s_reg;
    assign ival_diff = (ival_reg >= ival0_reg) ? (ival_reg - ival0_reg)
                                               : (ival0_reg - ival_reg);
    // Eight bit times span 64 prescale periods; round to nearest.
    assign cnt_round = {1'b0, cnt_reg} + 24'd32;
    assign p_full    = cnt_round >> 6;
    assign err_inc   = err_reg + 4'd1;

    assign bus.prescale  = prescale_reg;
    assign bus.locked    = locked_reg;
    assign bus.rx_hold   = ~locked_reg;
    assign bus.cal_error = cal_error_reg;
    assign bus.busy      = (state_reg == ST_WAIT_IDLE) || (state_reg == ST_HUNT) ||
                           (state_reg == ST_MEASURE)   || (state_reg == ST_CALC);

    // Two-flop synchronizer plus delay stage for edge detection; idle-high reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m_reg <= 1'b1;
            rxd_s_reg <= 1'b1;
            rxd_d_reg <= 1'b1;
        end else begin
            rxd_m_reg <= rxd;
            rxd_s_reg <= rxd_m_reg;
            rxd_d_reg <= rxd_s_reg;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            run_reg       <= '0;
            cnt_reg       <= '0;
            ival_reg      <= '0;
            ival0_reg     <= '0;
            edge_reg      <= '0;
            err_reg       <= '0;
            prescale_reg  <= DEFAULT_PRESCALE;
            locked_reg    <= 1'b0;
            cal_error_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            run_reg       <= run_next;
            cnt_reg       <= cnt_next;
            ival_reg      <= ival_next;
            ival0_reg     <= ival0_next;
            edge_reg      <= edge_next;
            err_reg       <= err_next;
            prescale_reg  <= prescale_next;
            locked_reg    <= locked_next;
            cal_error_reg <= cal_error_next;
        end
    end

    // Next-state and datapath decisions; run and error counters clear outside their states.
    always_comb begin
        state_next     = state_reg;
        run_next       = '0;
        cnt_next       = cnt_reg;
        ival_next      = ival_reg;
        ival0_next     = ival0_reg;
        edge_next      = edge_reg;
        err_next       = '0;
        prescale_next  = prescale_reg;
        locked_next    = locked_reg;
        cal_error_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) state_next = ST_WAIT_IDLE;
            end

            ST_WAIT_IDLE: begin
                if (rxd_s_reg) begin
                    if (run_reg == IDLE_LIM) state_next = ST_HUNT;
                    else                     run_next   = run_reg + 9'd1;
                end
            end

            ST_HUNT: begin
                cnt_next   = '0;
                ival_next  = '0;
                ival0_next = '0;
                edge_next  = '0;
                if (fe) state_next = ST_MEASURE;
            end

            ST_MEASURE: begin
                cnt_next  = cnt_reg + 23'd1;
                ival_next = ival_reg + 21'd1;
                if (ival_reg >= IVAL_LIM) begin
                    cal_error_next = 1'b1;
                    state_next     = ST_WAIT_IDLE;
                end else if (fe) begin
                    edge_next = edge_reg + 3'd1;
                    ival_next = 21'd1;
                    if (edge_reg == 3'd0) begin
                        ival0_next = ival_reg;
                    end else if (ival_diff > (ival0_reg >> 2)) begin
                        cal_error_next = 1'b1;
                        state_next     = ST_WAIT_IDLE;
                    end else if (edge_reg == 3'd3) begin
                        state_next = ST_CALC;
                    end
                end
            end

            ST_CALC: begin
                if ((p_full >= P_MIN) && (p_full <= P_MAX)) begin
                    prescale_next = p_full[15:0];
                    locked_next   = 1'b1;
                    state_next    = ST_LOCKED;
                end else begin
                    cal_error_next = 1'b1;
                    state_next     = ST_WAIT_IDLE;
                end
            end

            ST_LOCKED: begin
                err_next = err_reg;
                if (bus.frame_error)   err_next = err_inc;
                else if (bus.frame_ok) err_next = '0;
                if (bus.start || (bus.frame_error && (err_inc == ERR_LIM))) begin
                    err_next    = '0;
                    locked_next = 1'b0;
                    state_next  = ST_WAIT_IDLE;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_autobaud.sv
// Bench for uart_autobaud: directed 0x55 frames and control pulses, with a
// scoreboard of expected lock / unlock / cal_error events checked by a monitor.
module tb_uart_autobaud;
    localparam int EV_LOCK   = 0;
    localparam int EV_UNLOCK = 1;
    localparam int EV_CALERR = 2;

    typedef struct {
        int kind;
        int ps;
        int at;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic rxd   = 1'b1;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    logic locked_prev = 1'b0;

    uart_autobaud_if bus();

    uart_autobaud #(
        .DEFAULT_PRESCALE(16'd54),
        .IDLE_CYCLES(256),
        .MIN_PRESCALE(2),
        .IVAL_MAX(1000),
        .ERR_LIMIT(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rxd(rxd),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int kind, input int ps, input int at);
        exp_t e;
        e.kind = kind;
        e.ps   = ps;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Monitor: observed events are popped against the scoreboard.
    always @(negedge clk) begin
        int   kind;
        exp_t e;
        kind = -1;
        if (rst_n) begin
            if (bus.cal_error)                    kind = EV_CALERR;
            else if (bus.locked && !locked_prev)  kind = EV_LOCK;
            else if (!bus.locked && locked_prev)  kind = EV_UNLOCK;
        end
        locked_prev = bus.locked;
        if (kind >= 0) begin
            $display("event kind=%0d prescale=%0d locked=%0d busy=%0d cycle=%0d",
                     kind, bus.prescale, bus.locked, bus.busy, cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", kind, e.kind);
                chk("event_prescale", int'(bus.prescale), e.ps);
                chk("event_rx_hold", int'(bus.rx_hold), (e.kind == EV_LOCK) ? 0 : 1);
                chk("event_busy", int'(bus.busy), (e.kind == EV_LOCK) ? 0 : 1);
                if (e.at >= 0) chk("event_cycle", cyc, e.at);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit expect_unlock, input int ps);
        if (expect_unlock) push(EV_UNLOCK, ps, cyc + 1);
        bus.start = 1'b1;
        wait_cycles(1);
        bus.start = 1'b0;
    endtask

    task automatic pulse_ferr();
        bus.frame_error = 1'b1;
        wait_cycles(1);
        bus.frame_error = 1'b0;
        wait_cycles(3);
    endtask

    task automatic pulse_fok();
        bus.frame_ok = 1'b1;
        wait_cycles(1);
        bus.frame_ok = 1'b0;
        wait_cycles(3);
    endtask

    // Sends start + 8 data bits LSB-first + stop. One bit may be stretched.
    // The expected event is queued when the push_fe-th falling edge is driven.
    task automatic send_frame(input logic [7:0] data, input int period,
                              input int stretch_idx, input int stretch_len,
                              input int push_fe, input int kind, input int ps,
                              input int delay);
        logic lvl;
        int   n_fe;
        lvl  = rxd;
        n_fe = 0;
        for (int i = 0; i < 10; i++) begin
            logic b;
            int   len;
            if (i == 0)      b = 1'b0;
            else if (i == 9) b = 1'b1;
            else             b = data[i-1];
            len = (i == stretch_idx) ? stretch_len : period;
            if (lvl && !b) begin
                n_fe++;
                if (n_fe == push_fe) push(kind, ps, (delay < 0) ? -1 : cyc + delay);
            end
            rxd = b;
            lvl = b;
            wait_cycles(len);
        end
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            wait_cycles(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events still pending after %0d cycles, required 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_prescale"}, int'(bus.prescale), 54);
        chk({tag, "_locked"}, int'(bus.locked), 0);
        chk({tag, "_rx_hold"}, int'(bus.rx_hold), 1);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_cal_error"}, int'(bus.cal_error), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $fatal(1);
    end

    initial begin
        bus.start       = 1'b0;
        bus.frame_error = 1'b0;
        bus.frame_ok    = 1'b0;
        #2 rst_n = 1'b0;
        #20;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_cycles(2);

        // Nominal lock at 80 clk/bit: cnt=640 -> prescale 10, 4 cycles after 5th edge driven
        pulse_start(1'b0, 0);
        wait_cycles(2);
        chk("busy_wait_idle", int'(bus.busy), 1);
        wait_cycles(300);
        send_frame(8'h55, 80, -1, 0, 5, EV_LOCK, 10, 4);
        drain(50, "nominal");
        wait_cycles(20);

        // Rounding: 81 clk/bit -> cnt=648 -> 10
        pulse_start(1'b1, 10);
        wait_cycles(300);
        send_frame(8'h55, 81, -1, 0, 5, EV_LOCK, 10, 4);
        drain(50, "round_81");

        // Rounding: 84 clk/bit -> cnt=672 -> 11
        pulse_start(1'b1, 10);
        wait_cycles(300);
        send_frame(8'h55, 84, -1, 0, 5, EV_LOCK, 11, 4);
        drain(50, "round_84");

        // Tolerance: bit 3 stretched to 130 -> interval 210 vs ~160 fails
        pulse_start(1'b1, 11);
        wait_cycles(300);
        send_frame(8'h55, 80, 4, 130, 1, EV_CALERR, 11, -1);
        drain(50, "tolerance");
        chk("tol_locked", int'(bus.locked), 0);
        chk("tol_busy", int'(bus.busy), 1);
        chk("tol_prescale", int'(bus.prescale), 11);
        wait_cycles(300);
        send_frame(8'h55, 160, -1, 0, 5, EV_LOCK, 20, 4);
        drain(50, "relock_160");

        // Timeout: 0x00 gives one edge; ival hits 1000 -> cal_error 1004 cycles after drive
        pulse_start(1'b1, 20);
        wait_cycles(300);
        send_frame(8'h00, 80, -1, 0, 1, EV_CALERR, 20, 1004);
        drain(1000, "timeout");
        wait_cycles(300);

        // Minimum: 8 clk/bit -> p=1 -> cal_error from CALC
        send_frame(8'h55, 8, -1, 0, 5, EV_CALERR, 20, 4);
        drain(50, "min_prescale");
        chk("min_locked", int'(bus.locked), 0);
        wait_cycles(300);

        // Frame-error relock with ERR_LIMIT=3
        send_frame(8'h55, 80, -1, 0, 5, EV_LOCK, 10, 4);
        drain(50, "lock_for_ferr");
        wait_cycles(10);
        pulse_ferr();
        pulse_ferr();
        pulse_fok();
        pulse_ferr();
        chk("ferr_still_locked", int'(bus.locked), 1);
        chk("ferr_rx_hold_low", int'(bus.rx_hold), 0);
        pulse_ferr();
        chk("ferr_two_locked", int'(bus.locked), 1);
        push(EV_UNLOCK, 10, cyc + 1);
        pulse_ferr();
        drain(20, "ferr_unlock");
        chk("ferr_busy", int'(bus.busy), 1);

        // Reset in the middle of MEASURE after the 3rd falling edge
        wait_cycles(300);
        rxd = 1'b0; wait_cycles(80);
        rxd = 1'b1; wait_cycles(80);
        rxd = 1'b0; wait_cycles(80);
        rxd = 1'b1; wait_cycles(80);
        rxd = 1'b0; wait_cycles(10);
        chk("pre_reset_busy", int'(bus.busy), 1);
        chk("pre_reset_prescale", int'(bus.prescale), 10);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        rxd = 1'b1;
        #13 rst_n = 1'b1;
        wait_cycles(2);
        pulse_start(1'b0, 0);
        wait_cycles(300);
        send_frame(8'h55, 80, -1, 0, 5, EV_LOCK, 10, 4);
        drain(50, "post_reset_lock");
        wait_cycles(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
